// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
// Holds the instruction/PC widths, the PC increment, the fetch FSM state
// type, the FIFO entry layout and a word-alignment helper.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [PC_W-1:0]    PC_INC    = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,     // no request outstanding
    WAIT,     // request outstanding, data will be kept
    DISCARD   // request outstanding, data will be dropped (redirected)
  } fetch_state_t;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{pc: '0, instr: NOP_INSTR};

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Register-based synchronous FIFO used as the prefetch buffer.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, din    write din at the tail (ignored when full unless popping too)
//   pop          drop the head (ignored when empty)
//   flush        empty the FIFO; wins over push and pop
//   dout         head entry, read straight from the storage registers
//   count        number of valid entries, 0..DEPTH
module instr_fifo #(
  parameter int              DEPTH   = 4,
  parameter int              WIDTH   = 64,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int             AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  logic do_push;
  logic do_pop;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL_CNT) || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset because dout drives a core-visible output
      // directly and must come out of reset as a defined value.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RST_VAL;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch / prefetch stage in front of the CPU core.
// Walks a fetch PC, reads words from instruction memory one request at a
// time, buffers them in a prefetch FIFO and hands them to the core.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   mem_req, mem_addr       memory read request, held until mem_ack
//   mem_ack, mem_rdata      one-cycle completion pulse with the data
//   instr, instr_pc         FIFO head and its address
//   instr_valid, instr_ready  core handshake; head leaves when both high
//   redirect, redirect_pc   restart fetching at redirect_pc, flush all
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc
);

  localparam int              CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_CNT = CW'(DEPTH);

  fetch_state_t    state_q,    state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            mem_req_q,  mem_req_d;
  logic [PC_W-1:0] mem_addr_q, mem_addr_d;

  logic            push;
  logic            pop;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Next state. Only one request is ever outstanding, so in IDLE the FIFO
  // count alone tells whether the returning word will have a slot.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!redirect && (fifo_count < DEPTH_CNT)) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d = IDLE;
        end else if (redirect) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath next values.
  always_comb begin
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (state_d == WAIT) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          // An ack that coincides with a redirect carries stale data.
          if (!redirect) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_INC;
          end
        end
      end
      DISCARD: begin
        // The request cannot be withdrawn; wait for its ack and drop it.
        if (mem_ack) begin
          mem_req_d = 1'b0;
        end
      end
      default: mem_req_d = 1'b0;
    endcase
    if (redirect) begin
      fetch_pc_d = word_align(redirect_pc);
    end
  end

  assign push_entry  = '{pc: fetch_pc_q, instr: mem_rdata};
  assign instr_valid = (fifo_count != '0);
  assign pop         = instr_valid & instr_ready;

  instr_fifo #(
    .DEPTH   (DEPTH),
    .WIDTH   ($bits(fetch_entry_t)),
    .RST_VAL (EMPTY_ENTRY)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (push_entry),
    .dout  (head_entry),
    .count (fifo_count)
  );

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign instr    = head_entry.instr;
  assign instr_pc = head_entry.pc;

endmodule
